reg_operand_seq: RTL and testbench
==================================

REG_OPERAND_SEQ -- requirements
Module: reg_operand_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state updates on the rising edge of clk.
REQ-002 SHALL expose ports (name  direction  width  meaning):
  clk  in  1  system clock
  rst_n  in  1  async active-low reset
  req_valid  in  1  operation request present
  req_ready  out  1  block can accept request
  req_op  in  2  00 add, 01 sub, 10 and, 11 or
  req_rs  in  5  source A register address
  req_rt  in  5  source B register address
  req_rd  in  5  destination register address
  rf_r_address  out  5  register-file read address
  rf_r_enable  out  1  register-file read enable
  rf_data_out  in  32  register-file read data, combinational from rf_r_address
  rf_w_address  out  5  register-file write address
  rf_w_enable  out  1  register-file write enable
  rf_data_in  out  32  register-file write data
  result  out  32  last computed result
  done  out  1  one-cycle completion pulse
  busy  out  1  operation in progress

Function
REQ-003 SHALL implement FSM states IDLE, READ_A, READ_B, EXEC, WRITE; encoding free.
REQ-004 SHALL accept a request when req_valid && req_ready at a clock edge; SHALL capture req_op/rs/rt/rd into internal registers on that edge.
REQ-005 req_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of req_ready.
REQ-006 Transitions: IDLE->READ_A on accept; READ_A->READ_B; READ_B->EXEC; EXEC->WRITE; WRITE->IDLE; all unconditional except IDLE.
REQ-007 READ_A: rf_r_enable=1, rf_r_address=captured rs; operand A SHALL latch rf_data_out at the end of the cycle.
REQ-008 READ_B: rf_r_enable=1, rf_r_address=captured rt; operand B SHALL latch rf_data_out at the end of the cycle.
REQ-009 rf_r_enable SHALL be 0 in all other states; rf_r_address SHALL hold its last value.
REQ-010 EXEC: result register SHALL load op(A,B); add/sub modulo 2^32, carry/borrow discarded; and/or bitwise.
REQ-011 WRITE: rf_w_enable=1 for exactly one cycle, rf_w_address=captured rd, rf_data_in=result; all three driven from registers, stable and glitch-free for the whole cycle (the register file write is level-sensitive).
REQ-012 rf_w_enable SHALL be 0 in every state except WRITE.
REQ-013 done SHALL be 1 during the WRITE cycle only.
REQ-014 Latency: accept edge at cycle 0 -> WRITE/done in cycle 4; maximum throughput one operation per 5 cycles.
REQ-015 req_valid while busy SHALL be ignored; no queuing; requester holds req_valid until accepted.
REQ-016 rd equal to rs or rt SHALL be legal; operands are read before the write, so the old value is used.
REQ-017 Address 0 SHALL be treated as an ordinary register (no hardwired zero).
REQ-018 result SHALL hold its value after WRITE until the next EXEC.

Reset
REQ-019 On rst_n=0: state=IDLE, req_ready=1, busy=0, done=0, rf_r_enable=0, rf_w_enable=0, rf_r_address=0, rf_w_address=0, rf_data_in=0, result=0, operands and captured fields=0.
REQ-020 Reset asserted mid-operation SHALL abort it with no register-file write; the first accept after rst_n rises SHALL be possible on the first clock edge.

Verification
REQ-021 RF reg1=2, reg3=4; add rs=1 rt=3 rd=10 -> rf_w_enable single pulse 4 cycles after accept, address 10, data 6; done coincident.
REQ-022 sub rs=1 rt=3 rd=11 -> write 0xFFFFFFFE to reg11; add of 0xFFFFFFFF+1 -> 0x00000000.
REQ-023 add rs=3 rt=3 rd=3 (reg3=4) -> reg3 becomes 8; repeat -> 16.
REQ-024 req_valid held high continuously with two queued ops -> second accepted only in IDLE, 5 cycles after first; req_ready=0 throughout busy.
REQ-025 rst_n pulsed low during READ_B -> rf_w_enable never asserts, outputs at reset values, next request completes normally.
REQ-026 rf_r_enable checked low and rf_w_enable checked low in every non-READ/non-WRITE cycle across a random 200-operation run against a reference model.

Source files
------------

// File: rtl/reg_operand_seq.sv
// Register-operand sequencer: reads two source registers one at a time,
// applies add/sub/and/or, and writes the result back to a destination
// register. One operation is in flight at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; no register-file access
// S_READ_A | read address = rs; operand A latched at end of cycle
// S_READ_B | read address = rt; operand B latched at end of cycle
// S_EXEC   | result computed and registered with the write address
// S_WRITE  | one-cycle register-file write plus done pulse
module reg_operand_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   output logic [4:0]  rf_r_address,
   output logic        rf_r_enable,
   input  logic [31:0] rf_data_out,
   output logic [4:0]  rf_w_address,
   output logic        rf_w_enable,
   output logic [31:0] rf_data_in,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ_A = 3'd1,
      S_READ_B = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   state_t      r_state;
   logic [1:0]  r_op;
   logic [4:0]  r_rt;
   logic [4:0]  r_rd;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic [31:0] r_result;
   logic [4:0]  r_raddr;
   logic        r_ren;
   logic [4:0]  r_waddr;
   logic        r_wen;
   logic        r_done;
   logic        r_ready;
   logic [31:0] w_alu;

   // Operation on the latched operands; carry/borrow simply fall off the top.
   always_comb begin
      w_alu = r_opa | r_opb;
      case (r_op)
         OP_ADD:  w_alu = r_opa + r_opb;
         OP_SUB:  w_alu = r_opa - r_opb;
         OP_AND:  w_alu = r_opa & r_opb;
         default: w_alu = r_opa | r_opb;
      endcase
   end

   // Sequencer with all outputs registered one state ahead, so the write
   // strobe, address and data are flop outputs for the entire WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= 2'b00;
         r_rt     <= 5'd0;
         r_rd     <= 5'd0;
         r_opa    <= 32'd0;
         r_opb    <= 32'd0;
         r_result <= 32'd0;
         r_raddr  <= 5'd0;
         r_ren    <= 1'b0;
         r_waddr  <= 5'd0;
         r_wen    <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  // rs is only needed as the first read address, so it is
                  // captured straight into the read-address register.
                  r_op    <= req_op;
                  r_rt    <= req_rt;
                  r_rd    <= req_rd;
                  r_raddr <= req_rs;
                  r_ren   <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= S_READ_A;
               end
            end
            S_READ_A: begin
               r_opa   <= rf_data_out;
               r_raddr <= r_rt;
               r_state <= S_READ_B;
            end
            S_READ_B: begin
               r_opb   <= rf_data_out;
               r_ren   <= 1'b0;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_result <= w_alu;
               r_waddr  <= r_rd;
               r_wen    <= 1'b1;
               r_done   <= 1'b1;
               r_state  <= S_WRITE;
            end
            S_WRITE: begin
               r_wen   <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = r_ready;
   assign busy         = ~r_ready;
   assign rf_r_address = r_raddr;
   assign rf_r_enable  = r_ren;
   assign rf_w_address = r_waddr;
   assign rf_w_enable  = r_wen;
   assign rf_data_in   = r_result;
   assign result       = r_result;
   assign done         = r_done;

endmodule

// File: tb/tb_reg_operand_seq.sv
// Directed and random bench for reg_operand_seq with a behavioural
// register file and a per-cycle handshake/strobe monitor.
module tb_reg_operand_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [4:0]  rf_r_address;
   logic        rf_r_enable;
   logic [31:0] rf_data_out;
   logic [4:0]  rf_w_address;
   logic        rf_w_enable;
   logic [31:0] rf_data_in;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] rf [32];
   logic        tb_load;
   logic        mon_en;
   int          phase;
   logic [4:0]  exp_raddr;
   logic [4:0]  exp_rt;

   reg_operand_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_rs       (req_rs),
      .req_rt       (req_rt),
      .req_rd       (req_rd),
      .rf_r_address (rf_r_address),
      .rf_r_enable  (rf_r_enable),
      .rf_data_out  (rf_data_out),
      .rf_w_address (rf_w_address),
      .rf_w_enable  (rf_w_enable),
      .rf_data_in   (rf_data_in),
      .result       (result),
      .done         (done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: combinational read, edge write.
   assign rf_data_out = rf[rf_r_address];
   always @(posedge clk) begin
      if (tb_load) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
         rf[0] <= 32'd7;
         rf[1] <= 32'd2;
         rf[3] <= 32'd4;
         rf[5] <= 32'hFFFF_FFFF;
         rf[6] <= 32'd1;
      end else if (rf_w_enable) begin
         rf[rf_w_address] <= rf_data_in;
      end
   end

   // Reference phase: 0 idle, 1 read A, 2 read B, 3 exec, 4 write.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= 0;
         exp_raddr <= 5'd0;
         exp_rt    <= 5'd0;
      end else if (phase == 0) begin
         if (req_valid) begin
            phase     <= 1;
            exp_raddr <= req_rs;
            exp_rt    <= req_rt;
         end
      end else if (phase == 1) begin
         phase     <= 2;
         exp_raddr <= exp_rt;
      end else if (phase == 4) begin
         phase <= 0;
      end else begin
         phase <= phase + 1;
      end
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Per-cycle strobe and handshake check against the reference phase.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk32("mon_ready", {31'd0, req_ready}, {31'd0, phase == 0});
         chk32("mon_busy", {31'd0, busy}, {31'd0, phase != 0});
         chk32("mon_ren", {31'd0, rf_r_enable}, {31'd0, (phase == 1) || (phase == 2)});
         chk32("mon_wen", {31'd0, rf_w_enable}, {31'd0, phase == 4});
         chk32("mon_done", {31'd0, done}, {31'd0, phase == 4});
         if (phase == 1 || phase == 2)
            chk32("mon_raddr", {27'd0, rf_r_address}, {27'd0, exp_raddr});
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk32({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk32({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk32({tag, "_done"}, {31'd0, done}, 32'd0);
      chk32({tag, "_ren"}, {31'd0, rf_r_enable}, 32'd0);
      chk32({tag, "_wen"}, {31'd0, rf_w_enable}, 32'd0);
      chk32({tag, "_raddr"}, {27'd0, rf_r_address}, 32'd0);
      chk32({tag, "_waddr"}, {27'd0, rf_w_address}, 32'd0);
      chk32({tag, "_wdata"}, rf_data_in, 32'd0);
      chk32({tag, "_result"}, result, 32'd0);
   endtask

   // Issue one request from idle and check the write cycle four cycles on.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] exp);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_rs    = rs;
      req_rt    = rt;
      req_rd    = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk32({tag, "_wen"}, {31'd0, rf_w_enable}, 32'd1);
      chk32({tag, "_done"}, {31'd0, done}, 32'd1);
      chk32({tag, "_waddr"}, {27'd0, rf_w_address}, {27'd0, rd});
      chk32({tag, "_wdata"}, rf_data_in, exp);
      chk32({tag, "_result"}, result, exp);
      @(posedge clk);
      #1;
      chk32({tag, "_rf"}, rf[rd], exp);
      chk32({tag, "_wen_off"}, {31'd0, rf_w_enable}, 32'd0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [4:0]  r_rs;
      logic [4:0]  r_rt;
      logic [4:0]  r_rd;
      logic [31:0] r_exp;

      rst_n     = 1'b0;
      tb_load   = 1'b1;
      mon_en    = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_rs    = 5'd0;
      req_rt    = 5'd0;
      req_rd    = 5'd0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst");
      @(negedge clk);
      tb_load = 1'b0;
      rst_n   = 1'b1;
      #2 mon_en = 1'b1;

      do_op("add_1_3", 2'b00, 5'd1, 5'd3, 5'd10, 32'd6);
      do_op("sub_1_3", 2'b01, 5'd1, 5'd3, 5'd11, 32'hFFFF_FFFE);
      do_op("add_wrap", 2'b00, 5'd5, 5'd6, 5'd12, 32'd0);
      do_op("add_3_3_a", 2'b00, 5'd3, 5'd3, 5'd3, 32'd8);
      do_op("add_3_3_b", 2'b00, 5'd3, 5'd3, 5'd3, 32'd16);
      do_op("and_5_3", 2'b10, 5'd5, 5'd3, 5'd13, 32'd16);
      do_op("or_1_3", 2'b11, 5'd1, 5'd3, 5'd14, 32'd18);
      do_op("add_r0", 2'b00, 5'd0, 5'd1, 5'd0, 32'd9);
      do_op("add_0_0", 2'b00, 5'd0, 5'd0, 5'd15, 32'd18);

      // Two back-to-back requests with req_valid never dropped.
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 2'b00; req_rs = 5'd1; req_rt = 5'd6; req_rd = 5'd16;
      @(posedge clk);
      @(negedge clk);
      req_op = 2'b01; req_rs = 5'd3; req_rt = 5'd1; req_rd = 5'd17;
      repeat (3) @(posedge clk);
      #1;
      chk32("q1_waddr", {27'd0, rf_w_address}, 32'd16);
      chk32("q1_wdata", rf_data_in, 32'd3);
      @(posedge clk);
      #1;
      chk32("q1_rf", rf[16], 32'd3);
      chk32("q_idle_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk32("q2_accept_ren", {31'd0, rf_r_enable}, 32'd1);
      chk32("q2_accept_raddr", {27'd0, rf_r_address}, 32'd3);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk32("q2_wen", {31'd0, rf_w_enable}, 32'd1);
      chk32("q2_waddr", {27'd0, rf_w_address}, 32'd17);
      chk32("q2_wdata", rf_data_in, 32'd14);
      @(posedge clk);
      #1 chk32("q2_rf", rf[17], 32'd14);

      // Reset pulsed during READ_B must abort without any write.
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 2'b11; req_rs = 5'd1; req_rt = 5'd6; req_rd = 5'd20;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 chk32("abort_rf", rf[20], 32'd0);
      do_op("post_rst", 2'b00, 5'd1, 5'd6, 5'd21, 32'd3);
      chk32("abort_rf_late", rf[20], 32'd0);
      repeat (3) @(posedge clk);
      #1 chk32("result_hold", result, 32'd3);

      // Random run against the register-file contents as reference.
      for (int k = 0; k < 200; k++) begin
         r_op  = 2'($urandom_range(0, 3));
         r_rs  = 5'($urandom_range(0, 31));
         r_rt  = 5'($urandom_range(0, 31));
         r_rd  = 5'($urandom_range(0, 31));
         r_exp = alu(r_op, rf[r_rs], rf[r_rt]);
         do_op("rand", r_op, r_rs, r_rt, r_rd, r_exp);
      end

      repeat (2) @(posedge clk);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
